// File: rtl/placar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : placar_pkg
// Description : Shared types and constants for the placar score keeper.
// Revision    : 1.0 - initial release
// ============================================================================
package placar_pkg;

    localparam int BCD_DIGITS = 5;
    localparam int SCORE_W    = 20;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 20'h99999;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_OVER    = 2'd3
    } placar_state_t;

endpackage
`default_nettype wire

// File: rtl/placar_bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_add
// Description : One BCD digit plus a 4-bit addend and carry-in, with
//               decimal carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_add (
    input  logic [3:0] i_digit,
    input  logic [3:0] i_addend,
    input  logic       i_carry,
    output logic [3:0] o_sum,
    output logic       o_carry
);

    logic [4:0] w_raw;
    logic [4:0] w_adj;

    // Operands never exceed 9 + 9 + 1, so five bits hold the raw sum.
    assign w_raw   = {1'b0, i_digit} + {1'b0, i_addend} + {4'd0, i_carry};
    assign o_carry = (w_raw > 5'd9);
    assign w_adj   = w_raw - 5'd10;
    assign o_sum   = o_carry ? w_adj[3:0] : w_raw[3:0];

endmodule
`default_nettype wire

// File: rtl/placar.sv
`default_nettype none
// ============================================================================
// Module      : placar
// Description : Snake game score keeper: BCD score and session high score.
//               High-score tracking is built when PLACAR_HIGH_SCORE_EN is
//               defined; otherwise high_score and new_record read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module placar
    import placar_pkg::*;
#(
    parameter int unsigned POINTS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               fruta_eaten,
    input  logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               playing,
    output logic               new_record,
    output logic               saturated
);

    localparam logic [3:0] c_points = 4'(POINTS);

    placar_state_t       r_state;
    placar_state_t       w_state_nxt;
    logic [SCORE_W-1:0]  r_score;
    logic [SCORE_W-1:0]  w_score_nxt;
    logic                r_saturated;
    logic                w_saturated_nxt;
    logic                r_playing;
    logic                w_commit;
    logic                w_clear_record;

    logic [SCORE_W-1:0]  w_sum;
    logic [BCD_DIGITS:0] w_carry;
    logic [SCORE_W-1:0]  w_add_result;

    assign w_carry[0] = 1'b0;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        bcd_digit_add u_digit (
            .i_digit  (r_score[4*g +: 4]),
            .i_addend ((g == 0) ? c_points : 4'd0),
            .i_carry  (w_carry[g]),
            .o_sum    (w_sum[4*g +: 4]),
            .o_carry  (w_carry[g+1])
        );
    end

    // A carry out of the top digit means the true sum passed 99999.
    assign w_add_result = w_carry[BCD_DIGITS] ? SCORE_MAX : w_sum;

    always_comb begin
        w_state_nxt     = r_state;
        w_score_nxt     = r_score;
        w_saturated_nxt = r_saturated;
        w_commit        = 1'b0;
        w_clear_record  = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                if (new_game) begin
                    w_state_nxt     = ST_PLAYING;
                    w_score_nxt     = '0;
                    w_saturated_nxt = 1'b0;
                    w_clear_record  = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (fruta_eaten) begin
                    w_score_nxt     = w_add_result;
                    w_saturated_nxt = r_saturated | w_carry[BCD_DIGITS];
                end
                // The fruit add above still lands when the game ends this cycle.
                if (game_over) begin
                    w_state_nxt = ST_COMMIT;
                end else if (new_game) begin
                    w_score_nxt     = '0;
                    w_saturated_nxt = 1'b0;
                    w_clear_record  = 1'b1;
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_OVER;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_score     <= '0;
            r_saturated <= 1'b0;
            r_playing   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score     <= w_score_nxt;
            r_saturated <= w_saturated_nxt;
            r_playing   <= (w_state_nxt == ST_PLAYING);
        end
    end

    assign score     = r_score;
    assign saturated = r_saturated;
    assign playing   = r_playing;

`ifdef PLACAR_HIGH_SCORE_EN
    logic [SCORE_W-1:0] r_high_score;
    logic               r_new_record;

    // Digits stay within 0..9, so a binary compare orders BCD values correctly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_high_score <= '0;
            r_new_record <= 1'b0;
        end else if (w_commit && (r_score > r_high_score)) begin
            r_high_score <= r_score;
            r_new_record <= 1'b1;
        end else if (w_clear_record) begin
            r_new_record <= 1'b0;
        end
    end

    assign high_score = r_high_score;
    assign new_record = r_new_record;
`else
    logic w_unused_hs;
    assign w_unused_hs = w_commit | w_clear_record;
    assign high_score  = '0;
    assign new_record  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_placar.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_placar
// Description : Scoreboard bench for placar with POINTS of 1, 7 and 9.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_placar;

    typedef struct packed {
        logic [19:0] score;
        logic [19:0] high;
        logic        nr;
        logic        play;
        logic        sat;
    } obs_t;

`ifdef PLACAR_HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif
    localparam logic [19:0] HS31 = HS_EN ? 20'h00031 : 20'h00000;

    logic clk;
    logic reset_n;
    logic new_game;
    logic fruta_eaten;
    logic game_over;

    logic [19:0] score_a, high_a, score_b, high_b, score_c, high_c;
    logic        play_a, nr_a, sat_a, play_b, nr_b, sat_b, play_c, nr_c, sat_c;
    obs_t        obs_a, obs_b, obs_c;

    int   checks = 0;
    int   errors = 0;
    obs_t q[$];

    assign obs_a = {score_a, high_a, nr_a, play_a, sat_a};
    assign obs_b = {score_b, high_b, nr_b, play_b, sat_b};
    assign obs_c = {score_c, high_c, nr_c, play_c, sat_c};

    placar #(.POINTS(1)) u_a (
        .clk(clk), .reset(reset_n), .new_game(new_game), .fruta_eaten(fruta_eaten),
        .game_over(game_over), .score(score_a), .high_score(high_a),
        .playing(play_a), .new_record(nr_a), .saturated(sat_a));

    placar #(.POINTS(7)) u_b (
        .clk(clk), .reset(reset_n), .new_game(new_game), .fruta_eaten(fruta_eaten),
        .game_over(game_over), .score(score_b), .high_score(high_b),
        .playing(play_b), .new_record(nr_b), .saturated(sat_b));

    placar #(.POINTS(9)) u_c (
        .clk(clk), .reset(reset_n), .new_game(new_game), .fruta_eaten(fruta_eaten),
        .game_over(game_over), .score(score_c), .high_score(high_c),
        .playing(play_c), .new_record(nr_c), .saturated(sat_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic obs_t mk(input logic [19:0] s, input logic [19:0] h,
                                input logic nr, input logic p, input logic sat);
        return '{score: s, high: h, nr: nr, play: p, sat: sat};
    endfunction

    // Holds the given inputs across exactly one rising edge, returns 1ns after it.
    task automatic cycle(input logic ng, input logic fe, input logic go);
        new_game = ng; fruta_eaten = fe; game_over = go;
        @(posedge clk);
        #1;
        new_game = 1'b0; fruta_eaten = 1'b0; game_over = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        reset_n = 1'b0; new_game = 1'b0; fruta_eaten = 1'b0; game_over = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b0, 1'b0));
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL reset_a got %h want %h", obs_a, e); end
        e = q.pop_front(); checks++;
        if (obs_c !== e) begin errors++; $display("FAIL reset_c got %h want %h", obs_c, e); end
        reset_n = 1'b1;
    endtask

    task automatic test_count();
        obs_t e;
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b1, 1'b0));
        cycle(1'b1, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL new_game got %h want %h", obs_a, e); end
        for (int i = 1; i <= 12; i++) begin
            q.push_back(mk(bcd(i), 20'h0, 1'b0, 1'b1, 1'b0));
            cycle(1'b0, 1'b1, 1'b0);
            e = q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL count_%0d got %h want %h", i, obs_a, e); end
        end
    endtask

    task automatic test_carry();
        obs_t e;
        // POINTS=7 instance sits at 84 after twelve fruits; 98 -> 105 ripples two digits.
        for (int i = 13; i <= 15; i++) begin
            q.push_back(mk(bcd(7 * i), 20'h0, 1'b0, 1'b1, 1'b0));
            cycle(1'b0, 1'b1, 1'b0);
            e = q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL carry_%0d got %h want %h", i, obs_b, e); end
        end
    endtask

    task automatic test_saturate();
        obs_t e;
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b1, 1'b0));
        cycle(1'b1, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_b !== e) begin errors++; $display("FAIL restart_b got %h want %h", obs_b, e); end
        repeat (14284) cycle(1'b0, 1'b1, 1'b0);
        q.push_back(mk(20'h99988, 20'h0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(20'h99999, 20'h0, 1'b0, 1'b1, 1'b1));
        q.push_back(mk(bcd(14284), 20'h0, 1'b0, 1'b1, 1'b0));
        e = q.pop_front(); checks++;
        if (obs_b !== e) begin errors++; $display("FAIL pre_sat_b got %h want %h", obs_b, e); end
        e = q.pop_front(); checks++;
        if (obs_c !== e) begin errors++; $display("FAIL sat_c got %h want %h", obs_c, e); end
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL long_count_a got %h want %h", obs_a, e); end
        q.push_back(mk(20'h99995, 20'h0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(20'h99999, 20'h0, 1'b0, 1'b1, 1'b1));
        q.push_back(mk(20'h99999, 20'h0, 1'b0, 1'b1, 1'b1));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            e = q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL sat_b_%0d got %h want %h", i, obs_b, e); end
        end
    endtask

    task automatic test_restart();
        obs_t e;
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b1, 1'b0));
        cycle(1'b1, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_c !== e) begin errors++; $display("FAIL restart_c got %h want %h", obs_c, e); end
    endtask

    task automatic test_commit();
        obs_t e;
        repeat (30) cycle(1'b0, 1'b1, 1'b0);
        q.push_back(mk(20'h00030, 20'h0, 1'b0, 1'b1, 1'b0));
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL pre_commit got %h want %h", obs_a, e); end
        q.push_back(mk(20'h00031, 20'h0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(20'h00031, HS31, HS_EN, 1'b0, 1'b0));
        q.push_back(mk(20'h00031, HS31, HS_EN, 1'b0, 1'b0));
        cycle(1'b0, 1'b1, 1'b1);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL commit_n got %h want %h", obs_a, e); end
        cycle(1'b0, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL commit_n1 got %h want %h", obs_a, e); end
        cycle(1'b0, 1'b1, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL over_fruit got %h want %h", obs_a, e); end
    endtask

    task automatic test_second_game();
        obs_t e;
        q.push_back(mk(20'h0, HS31, 1'b0, 1'b1, 1'b0));
        cycle(1'b1, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL over_new_game got %h want %h", obs_a, e); end
        repeat (10) cycle(1'b0, 1'b1, 1'b0);
        // game_over must win over a simultaneous new_game.
        q.push_back(mk(20'h00010, HS31, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(20'h00010, HS31, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(20'h00010, HS31, 1'b0, 1'b0, 1'b0));
        cycle(1'b1, 1'b0, 1'b1);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL go_beats_ng got %h want %h", obs_a, e); end
        cycle(1'b0, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL low_commit got %h want %h", obs_a, e); end
        cycle(1'b0, 1'b1, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL over_fruit2 got %h want %h", obs_a, e); end
    endtask

    task automatic test_async_reset();
        obs_t e;
        cycle(1'b1, 1'b0, 1'b0);
        repeat (50) cycle(1'b0, 1'b1, 1'b0);
        q.push_back(mk(20'h00050, HS31, 1'b0, 1'b0, 1'b0));
        cycle(1'b0, 1'b0, 1'b1);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL in_commit got %h want %h", obs_a, e); end
        #2;
        reset_n = 1'b0;
        #1;
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b0, 1'b0));
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL async_clear got %h want %h", obs_a, e); end
        @(posedge clk);
        #1;
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b0, 1'b0));
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL commit_lost got %h want %h", obs_a, e); end
        reset_n = 1'b1;
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(20'h0, 20'h0, 1'b0, 1'b0, 1'b0));
        cycle(1'b0, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL idle_after_rst got %h want %h", obs_a, e); end
        cycle(1'b1, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL play_after_rst got %h want %h", obs_a, e); end
        cycle(1'b0, 1'b0, 1'b1);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL zero_commit_n got %h want %h", obs_a, e); end
        cycle(1'b0, 1'b0, 1'b0);
        e = q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL zero_commit_n1 got %h want %h", obs_a, e); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry();
        test_saturate();
        test_restart();
        test_commit();
        test_second_game();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
